// File: rtl/lagarto0_pkg.sv
// Shared fetch-side constants and the instruction cache FSM state type.
// Contents: address/line sizes, direct-mapped geometry derived from
// ICACHE_NUM_LINES, and icache_state_e.
package lagarto0_pkg;

   localparam int unsigned ADDR_SIZE        = 32;
   localparam int unsigned ICACHE_LINE_SIZE = 128;

   localparam int unsigned ICACHE_NUM_LINES = 16;
   localparam int unsigned ICACHE_OFFSET_W  = $clog2(ICACHE_LINE_SIZE / 8);
   localparam int unsigned ICACHE_INDEX_W   = $clog2(ICACHE_NUM_LINES);
   localparam int unsigned ICACHE_TAG_W     = ADDR_SIZE - ICACHE_OFFSET_W - ICACHE_INDEX_W;

   typedef enum logic [1:0] {
      ICACHE_IDLE   = 2'd0,
      ICACHE_MISS   = 2'd1,
      ICACHE_REFILL = 2'd2
   } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/data/valid storage for the direct-mapped instruction cache.
// Ports: clk_i/rst_ni (sync, active-low, clears valid bits only),
//        rd_en_i/rd_idx_i -> registered rd_valid_o/rd_tag_o/rd_data_o,
//        wr_en_i/wr_idx_i/wr_tag_i/wr_data_i/wr_valid_i write port,
//        clr_i flash-clears every valid bit (wins over a same-cycle write).
module icache_array #(
   parameter int unsigned NUM_LINES = 16,
   parameter int unsigned TAG_W     = 24,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rd_en_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_valid_i,
   input  logic              clr_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [DATA_W-1:0]    data_q [NUM_LINES];
   logic                 rd_valid_q;
   logic [TAG_W-1:0]     rd_tag_q;
   logic [DATA_W-1:0]    rd_data_q;

   // Valid bits: the only reset state in the array.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (clr_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end
   end

   // Tag and data storage, never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Registered read port.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_valid_q <= 1'b0;
      end else if (rd_en_i) begin
         rd_valid_q <= valid_q[rd_idx_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_tag_q  <= tag_q[rd_idx_i];
         rd_data_q <= data_q[rd_idx_i];
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_tag_o   = rd_tag_q;
   assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, blocking instruction cache with single-line refill.
// Ports: clk_i, rst_ni (sync, active-low); fetch side req_i/pc_i/flush_i ->
//        inst_o/hit_o/busy_o; memory side mem_req_o/mem_addr_o ->
//        mem_valid_i/mem_data_i.
// Optional: define ICACHE_STATS_EN to add saturating 32-bit hit_cnt_o and
//           miss_cnt_o counters of accepted lookups.
// A lookup is sampled on one edge and resolved in the following cycle; a
// miss moves to MISS on the edge after that, so the fastest miss-to-hit is
// three cycles. A request presented in the cycle a miss is detected is
// dropped; the fetch stage sees hit_o=0 and re-issues it.
module icache_dm
   import lagarto0_pkg::*;
#(
   parameter int unsigned NUM_LINES = ICACHE_NUM_LINES
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_i,
   input  logic [ADDR_SIZE-1:0]        pc_i,
   input  logic                        flush_i,
   output logic [ICACHE_LINE_SIZE-1:0] inst_o,
   output logic                        hit_o,
   output logic                        busy_o,
   output logic                        mem_req_o,
   output logic [ADDR_SIZE-1:0]        mem_addr_o,
   input  logic                        mem_valid_i,
   input  logic [ICACHE_LINE_SIZE-1:0] mem_data_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]                 hit_cnt_o,
   output logic [31:0]                 miss_cnt_o
`endif
);

   localparam int unsigned OFF_W = ICACHE_OFFSET_W;
   localparam int unsigned IDX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W = ADDR_SIZE - OFF_W - IDX_W;

   icache_state_e               state_q, state_d;
   logic                        lookup_q, lookup_d;
   logic [TAG_W-1:0]            lkp_tag_q;
   logic [IDX_W-1:0]            lkp_idx_q;
   logic [ADDR_SIZE-1:0]        miss_addr_q, miss_addr_d;
   logic                        flush_pend_q, flush_pend_d;
   logic [ICACHE_LINE_SIZE-1:0] refill_q, refill_d;

   logic                        rd_valid;
   logic [TAG_W-1:0]            rd_tag;
   logic [ICACHE_LINE_SIZE-1:0] rd_data;
   logic                        wr_en_c, wr_valid_c;
   logic                        lkp_hit_c;
   logic                        unused_offset;

   // Offset bits only select a word inside the line; the line is returned whole.
   assign unused_offset = ^pc_i[OFF_W-1:0];

   icache_array #(
      .NUM_LINES (NUM_LINES),
      .TAG_W     (TAG_W),
      .DATA_W    (ICACHE_LINE_SIZE),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rd_en_i    (lookup_d),
      .rd_idx_i   (pc_i[OFF_W +: IDX_W]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en_c),
      .wr_idx_i   (miss_addr_q[OFF_W +: IDX_W]),
      .wr_tag_i   (miss_addr_q[ADDR_SIZE-1 -: TAG_W]),
      .wr_data_i  (mem_data_i),
      .wr_valid_i (wr_valid_c),
      .clr_i      (flush_i)
   );

   // lookup_q is only ever set while IDLE, so it qualifies the compare alone.
   assign lkp_hit_c = lookup_q & rd_valid & (rd_tag == lkp_tag_q);

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      lookup_d     = 1'b0;
      miss_addr_d  = miss_addr_q;
      flush_pend_d = flush_pend_q;
      refill_d     = refill_q;
      wr_en_c      = 1'b0;
      wr_valid_c   = 1'b0;
      unique case (state_q)
         ICACHE_IDLE: begin
            if (lookup_q && !lkp_hit_c) begin
               state_d      = ICACHE_MISS;
               miss_addr_d  = {lkp_tag_q, lkp_idx_q, {OFF_W{1'b0}}};
               flush_pend_d = flush_i;
            end else begin
               // A same-cycle flush cancels the request outright.
               lookup_d = req_i & ~flush_i;
            end
         end
         ICACHE_MISS: begin
            if (flush_i) begin
               flush_pend_d = 1'b1;
            end
            if (mem_valid_i) begin
               wr_en_c    = 1'b1;
               wr_valid_c = ~(flush_pend_q | flush_i);
               refill_d   = mem_data_i;
               state_d    = ICACHE_REFILL;
            end
         end
         ICACHE_REFILL: begin
            state_d = ICACHE_IDLE;
         end
         default: begin
            state_d = ICACHE_IDLE;
         end
      endcase
   end

   // Control state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= ICACHE_IDLE;
         lookup_q     <= 1'b0;
         miss_addr_q  <= '0;
         flush_pend_q <= 1'b0;
         refill_q     <= '0;
      end else begin
         state_q      <= state_d;
         lookup_q     <= lookup_d;
         miss_addr_q  <= miss_addr_d;
         flush_pend_q <= flush_pend_d;
         refill_q     <= refill_d;
      end
   end

   // Tag/index of the lookup in flight, paired with the array read.
   always_ff @(posedge clk_i) begin
      if (lookup_d) begin
         lkp_tag_q <= pc_i[ADDR_SIZE-1 -: TAG_W];
         lkp_idx_q <= pc_i[OFF_W +: IDX_W];
      end
   end

   assign hit_o      = (state_q == ICACHE_REFILL) | lkp_hit_c;
   assign inst_o     = (state_q == ICACHE_REFILL) ? refill_q :
                       lkp_hit_c                  ? rd_data  : '0;
   assign busy_o     = (state_q != ICACHE_IDLE);
   assign mem_req_o  = (state_q == ICACHE_MISS);
   assign mem_addr_o = miss_addr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Saturating counters of resolved lookups; flush does not touch them.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (lookup_q) begin
         if (lkp_hit_c) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: a reference cache model predicts each
// lookup, expectations are queued at drive time and popped on the result cycle.
module tb_icache_dm;
   import lagarto0_pkg::*;

   localparam int unsigned NL    = 16;
   localparam int unsigned LB    = ICACHE_LINE_SIZE / 8;
   localparam int unsigned LW    = ICACHE_LINE_SIZE;
   localparam int unsigned OFF_W = $clog2(LB);

   typedef struct packed {
      logic          hit;
      logic [LW-1:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_ni;
   logic                 req_i;
   logic [ADDR_SIZE-1:0] pc_i;
   logic                 flush_i;
   logic [LW-1:0]        inst_o;
   logic                 hit_o;
   logic                 busy_o;
   logic                 mem_req_o;
   logic [ADDR_SIZE-1:0] mem_addr_o;
   logic                 mem_valid_i;
   logic [LW-1:0]        mem_data_i;
`ifdef ICACHE_STATS_EN
   logic [31:0]          hit_cnt, miss_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   exp_t exp_q[$];

   logic                 m_valid [NL];
   logic [ADDR_SIZE-1:0] m_line  [NL];
   logic [LW-1:0]        m_data  [NL];
   int unsigned          m_hits, m_misses;

   always #5 clk = ~clk;

   icache_dm #(.NUM_LINES(NL)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .pc_i        (pc_i),
      .flush_i     (flush_i),
      .inst_o      (inst_o),
      .hit_o       (hit_o),
      .busy_o      (busy_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_valid_i (mem_valid_i),
      .mem_data_i  (mem_data_i)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int unsigned idx_of(input logic [ADDR_SIZE-1:0] a);
      return int'((a >> OFF_W) % NL);
   endfunction

   function automatic logic [ADDR_SIZE-1:0] line_of(input logic [ADDR_SIZE-1:0] a);
      return a & ~ADDR_SIZE'(LB - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni      = 1'b0;
      req_i       = 1'b0;
      flush_i     = 1'b0;
      mem_valid_i = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      model_clear();
      m_hits   = 0;
      m_misses = 0;
      exp_q.delete();
   endtask

   task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
      check_eq({tag, ".hit_cnt"},  LW'(hit_cnt),  LW'(m_hits));
      check_eq({tag, ".miss_cnt"}, LW'(miss_cnt), LW'(m_misses));
`endif
   endtask

   // Drives one lookup (req_i stays high so calls chain back to back).
   task automatic lookup(input string tag, input logic [ADDR_SIZE-1:0] a, input logic flush);
      exp_t e, got;
      int unsigned i;
      i      = idx_of(a);
      e.hit  = !flush && m_valid[i] && (m_line[i] == line_of(a));
      e.data = e.hit ? m_data[i] : '0;
      if (!flush) begin
         if (e.hit) m_hits++;
         else       m_misses++;
      end else begin
         model_clear();
      end
      exp_q.push_back(e);
      req_i   = 1'b1;
      pc_i    = a;
      flush_i = flush;
      tick();
      flush_i = 1'b0;
      got = exp_q.pop_front();
      check_eq({tag, ".hit"},  LW'(hit_o), LW'(got.hit));
      check_eq({tag, ".inst"}, inst_o,     got.data);
   endtask

   // Called in the cycle after a missing lookup resolves.
   task automatic refill(input string tag, input logic [ADDR_SIZE-1:0] a, input logic [LW-1:0] d,
                         input int delay, input int flush_at);
      exp_t e, got;
      logic flushed;
      flushed = 1'b0;
      req_i   = 1'b0;
      tick();
      check_eq({tag, ".mreq"},  LW'(mem_req_o),  LW'(1'b1));
      check_eq({tag, ".maddr"}, LW'(mem_addr_o), LW'(line_of(a)));
      check_eq({tag, ".busy"},  LW'(busy_o),     LW'(1'b1));
      for (int k = 0; k < delay; k++) begin
         if (k == flush_at) begin
            flush_i = 1'b1;
            flushed = 1'b1;
            model_clear();
         end
         tick();
         flush_i = 1'b0;
         check_eq({tag, ".mreq_hold"},  LW'(mem_req_o),  LW'(1'b1));
         check_eq({tag, ".maddr_hold"}, LW'(mem_addr_o), LW'(line_of(a)));
      end
      e.hit  = 1'b1;
      e.data = d;
      exp_q.push_back(e);
      mem_valid_i = 1'b1;
      mem_data_i  = d;
      tick();
      mem_valid_i = 1'b0;
      mem_data_i  = '0;
      got = exp_q.pop_front();
      check_eq({tag, ".rf_hit"},  LW'(hit_o),  LW'(got.hit));
      check_eq({tag, ".rf_inst"}, inst_o,      got.data);
      check_eq({tag, ".rf_busy"}, LW'(busy_o), LW'(1'b1));
      m_valid[idx_of(a)] = !flushed;
      m_line[idx_of(a)]  = line_of(a);
      m_data[idx_of(a)]  = d;
      tick();
      check_eq({tag, ".post_busy"}, LW'(busy_o), LW'(1'b0));
      check_eq({tag, ".post_hit"},  LW'(hit_o),  LW'(1'b0));
   endtask

   task automatic idle();
      req_i = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LW-1:0] da5, d2, d3, d4;
      logic [LW-1:0] junk;
      da5 = {16{8'hA5}};
      d2  = {4{32'h1234_5678}};
      d3  = {4{32'hCAFE_0001}};
      d4  = {4{32'h0BAD_F00D}};
      junk = {8{16'hDEAD}};
      pc_i       = '0;
      mem_data_i = '0;
      do_reset();
      check_eq("rst.hit",   LW'(hit_o),      '0);
      check_eq("rst.busy",  LW'(busy_o),     '0);
      check_eq("rst.mreq",  LW'(mem_req_o),  '0);
      check_eq("rst.maddr", LW'(mem_addr_o), '0);
      check_eq("rst.inst",  inst_o,          '0);
      check_stats("rst");

      // Cold miss, slow refill, then hit on another word of the line.
      lookup("cold", 32'h1000, 1'b0);
      refill("cold", 32'h1000, da5, 5, -1);
      lookup("rehit", 32'h1004, 1'b0);
      check_eq("rehit.mreq", LW'(mem_req_o), '0);
      idle();

      // Conflict eviction on the same index.
      lookup("conf", 32'h1000 + NL * LB, 1'b0);
      refill("conf", 32'h1000 + NL * LB, d2, 0, -1);
      lookup("evict", 32'h1000, 1'b0);
      refill("evict", 32'h1000, da5, 2, -1);

      // Back-to-back hits across several lines.
      lookup("f1", 32'h2010, 1'b0);
      refill("f1", 32'h2010, d3, 1, -1);
      lookup("f2", 32'h202c, 1'b0);
      refill("f2", 32'h202c, d4, 0, -1);
      lookup("b2b0", 32'h1008, 1'b0);
      lookup("b2b1", 32'h2014, 1'b0);
      lookup("b2b2", 32'h2020, 1'b0);
      lookup("b2b3", 32'h100c, 1'b0);
      idle();

      // Stray memory response in IDLE is ignored.
      mem_valid_i = 1'b1;
      mem_data_i  = junk;
      tick();
      mem_valid_i = 1'b0;
      mem_data_i  = '0;
      check_eq("stray.hit",  LW'(hit_o),  '0);
      check_eq("stray.busy", LW'(busy_o), '0);
      check_eq("stray.inst", inst_o,      '0);
      lookup("stray.after", 32'h1000, 1'b0);
      idle();

      // Flush alongside a request to a resident line.
      lookup("flreq", 32'h1000, 1'b1);
      req_i = 1'b0;
      check_eq("flreq.busy", LW'(busy_o), '0);
      tick();
      check_eq("flreq.mreq", LW'(mem_req_o), '0);
      check_eq("flreq.busy2", LW'(busy_o), '0);
      lookup("flreq.next", 32'h1000, 1'b0);
      refill("flreq.next", 32'h1000, da5, 0, -1);

      // Flush during MISS: data delivered, line left invalid.
      lookup("flmiss", 32'h3000, 1'b0);
      refill("flmiss", 32'h3000, d2, 3, 1);
      lookup("flmiss.again", 32'h3000, 1'b0);
      refill("flmiss.again", 32'h3000, d2, 0, -1);
      lookup("flmiss.hit", 32'h3008, 1'b0);
      idle();

      // Reset in the middle of a miss, then a late memory response.
      lookup("rstmiss", 32'h4010, 1'b0);
      req_i = 1'b0;
      tick();
      check_eq("rstmiss.mreq", LW'(mem_req_o), LW'(1'b1));
      do_reset();
      check_eq("rstmiss.busy",  LW'(busy_o),     '0);
      check_eq("rstmiss.mreq0", LW'(mem_req_o),  '0);
      check_eq("rstmiss.maddr", LW'(mem_addr_o), '0);
      check_stats("rstmiss");
      mem_valid_i = 1'b1;
      mem_data_i  = junk;
      tick();
      mem_valid_i = 1'b0;
      check_eq("late.hit",  LW'(hit_o),  '0);
      check_eq("late.busy", LW'(busy_o), '0);
      lookup("late.miss", 32'h4010, 1'b0);
      refill("late.miss", 32'h4010, d3, 0, -1);

      // Fixed stats scenario: 3 hits and 2 misses after a fresh reset.
      do_reset();
      lookup("st.m0", 32'h5000, 1'b0);
      refill("st.m0", 32'h5000, d4, 0, -1);
      lookup("st.h0", 32'h5000, 1'b0);
      lookup("st.h1", 32'h5004, 1'b0);
      idle();
      lookup("st.m1", 32'h6010, 1'b0);
      refill("st.m1", 32'h6010, d2, 1, -1);
      lookup("st.h2", 32'h6018, 1'b0);
      idle();
      check_stats("st");
`ifdef ICACHE_STATS_EN
      check_eq("st.hit3",  LW'(hit_cnt),  LW'(32'd3));
      check_eq("st.miss2", LW'(miss_cnt), LW'(32'd2));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
